// File: rtl/fc_layer_sequencer.sv
// Time-multiplexed fully connected layer controller: walks NUM_OUTPUTS dot products of
// INPUT_SIZE terms through one shared external fma unit and streams one result per neuron.
module fc_layer_sequencer #(
    parameter int INPUT_SIZE  = 32,
    parameter int NUM_OUTPUTS = 16,
    parameter int FMA_LAT     = 1,
    localparam int IA_W = (INPUT_SIZE > 1) ? $clog2(INPUT_SIZE) : 1,
    localparam int WA_W = (INPUT_SIZE * NUM_OUTPUTS > 1) ? $clog2(INPUT_SIZE * NUM_OUTPUTS) : 1,
    localparam int OA_W = (NUM_OUTPUTS > 1) ? $clog2(NUM_OUTPUTS) : 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    output logic            busy,
    output logic            done,
    output logic            rd_en,
    output logic [IA_W-1:0] in_addr,
    output logic [WA_W-1:0] w_addr,
    input  logic [31:0]     in_rdata,
    input  logic [31:0]     w_rdata,
    output logic [31:0]     fma_a,
    output logic [31:0]     fma_b,
    output logic [31:0]     fma_c,
    input  logic [31:0]     fma_result,
    output logic [31:0]     out_data,
    output logic [OA_W-1:0] out_idx,
    output logic            out_valid,
    input  logic            out_ready
);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_READ = 3'd1;
    localparam logic [2:0] S_LOAD = 3'd2;
    localparam logic [2:0] S_WAIT = 3'd3;
    localparam logic [2:0] S_ACC  = 3'd4;
    localparam logic [2:0] S_OUT  = 3'd5;
    localparam logic [2:0] S_DONE = 3'd6;

    localparam int              CNT_W     = (FMA_LAT > 2) ? $clog2(FMA_LAT - 1) : 1;
    localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'((FMA_LAT > 1) ? FMA_LAT - 2 : 0);
    localparam logic [IA_W-1:0]  I_LAST    = IA_W'(INPUT_SIZE - 1);
    localparam logic [OA_W-1:0]  J_LAST    = OA_W'(NUM_OUTPUTS - 1);

    logic [2:0]       state_q, state_d;
    logic [IA_W-1:0]  i_q, i_d;
    logic [OA_W-1:0]  j_q, j_d;
    logic [WA_W-1:0]  w_q, w_d;
    logic [31:0]      acc_q, acc_d;
    logic [31:0]      fb_q, fb_d;
    logic [31:0]      fc_q, fc_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // w_q tracks j*INPUT_SIZE+i incrementally: every term step and every row step adds one.
    always_comb begin
        state_d = state_q;
        i_d     = i_q;
        j_d     = j_q;
        w_d     = w_q;
        acc_d   = acc_q;
        fb_d    = fb_q;
        fc_d    = fc_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    i_d     = '0;
                    j_d     = '0;
                    w_d     = '0;
                    acc_d   = '0;
                    state_d = S_READ;
                end
            end
            S_READ: state_d = S_LOAD;
            S_LOAD: begin
                fb_d    = w_rdata;
                fc_d    = in_rdata;
                cnt_d   = '0;
                state_d = (FMA_LAT > 1) ? S_WAIT : S_ACC;
            end
            S_WAIT: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == WAIT_LAST) state_d = S_ACC;
            end
            S_ACC: begin
                acc_d = fma_result;
                if (i_q == I_LAST) begin
                    state_d = S_OUT;
                end else begin
                    i_d     = i_q + 1'b1;
                    w_d     = w_q + 1'b1;
                    state_d = S_READ;
                end
            end
            S_OUT: begin
                if (out_ready) begin
                    if (j_q == J_LAST) begin
                        state_d = S_DONE;
                    end else begin
                        j_d     = j_q + 1'b1;
                        i_d     = '0;
                        w_d     = w_q + 1'b1;
                        acc_d   = '0;
                        state_d = S_READ;
                    end
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            i_q     <= '0;
            j_q     <= '0;
            w_q     <= '0;
            acc_q   <= '0;
            fb_q    <= '0;
            fc_q    <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            i_q     <= i_d;
            j_q     <= j_d;
            w_q     <= w_d;
            acc_q   <= acc_d;
            fb_q    <= fb_d;
            fc_q    <= fc_d;
            cnt_q   <= cnt_d;
        end
    end

    assign busy      = (state_q != S_IDLE);
    assign done      = (state_q == S_DONE);
    assign rd_en     = (state_q == S_READ);
    assign out_valid = (state_q == S_OUT);
    assign in_addr   = i_q;
    assign w_addr    = w_q;
    assign fma_a     = acc_q;
    assign fma_b     = fb_q;
    assign fma_c     = fc_q;
    assign out_data  = acc_q;
    assign out_idx   = j_q;

endmodule
